// File: rtl/mux_scan_ctrl.sv
// ============================================================================
// mux_scan_ctrl : scans enabled inputs of an external 8:1 mux in ascending order
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ch_mask,
  input  logic       y_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time each channel goes straight to its sample cycle.
  localparam state_t LOAD_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [7:0] r_pending;
  logic [7:0] w_remaining;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  assign w_remaining = r_pending & ~(8'h01 << sel);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (ch_mask == 8'h00) ? ST_DONE : LOAD_STATE;
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_next = (w_remaining != 8'h00) ? LOAD_STATE : ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel          <= 3'd0;
      result       <= 8'h00;
      result_valid <= 1'b0;
      r_cnt        <= 4'd0;
      r_pending    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pending    <= ch_mask;
            result       <= 8'h00;
            result_valid <= 1'b0;
            r_cnt        <= 4'd0;
            // An empty mask leaves sel where it was.
            if (ch_mask != 8'h00) sel <= lowest(ch_mask);
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) r_cnt <= 4'd0;
          else                      r_cnt <= r_cnt + 4'd1;
        end
        ST_SAMPLE: begin
          result[sel] <= y_in;
          r_pending   <= w_remaining;
          r_cnt       <= 4'd0;
          if (w_remaining != 8'h00) sel <= lowest(w_remaining);
        end
        ST_DONE: begin
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// ============================================================================
// tb_mux_scan_ctrl : randomized scans on three settle settings vs. a timing model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] ch_mask;
  logic [7:0] mux_in;

  logic [ND-1:0]      y_in_v;
  logic [ND-1:0]      busy_v;
  logic [ND-1:0]      done_v;
  logic [ND-1:0]      rv_v;
  logic [ND-1:0][2:0] sel_v;
  logic [ND-1:0][7:0] res_v;

  int checks = 0;
  int errors = 0;
  logic [2:0] prev_sel [ND];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      assign y_in_v[g] = mux_in[sel_v[g]];
      mux_scan_ctrl #(.SETTLE((g == 0) ? 1 : ((g == 1) ? 0 : 3))) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ch_mask      (ch_mask),
        .y_in         (y_in_v[g]),
        .sel          (sel_v[g]),
        .busy         (busy_v[g]),
        .done         (done_v[g]),
        .result       (res_v[g]),
        .result_valid (rv_v[g])
      );
    end
  endgenerate

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h", tag, d, got, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk({tag, "_sel"},  d, 32'(sel_v[d]),  32'd0);
      chk({tag, "_busy"}, d, 32'(busy_v[d]), 32'd0);
      chk({tag, "_done"}, d, 32'(done_v[d]), 32'd0);
      chk({tag, "_res"},  d, 32'(res_v[d]),  32'd0);
      chk({tag, "_rv"},   d, 32'(rv_v[d]),   32'd0);
    end
  endtask

  // Expected behaviour: the n enabled channels are visited low to high, each for
  // S+1 cycles; done appears n*(S+1)+1 cycles after the accepting edge.
  task automatic run_scan(input logic [7:0] mask, input logic [7:0] ins, input bit disturb);
    int bits [8];
    int n;
    int len [ND];
    int lmax;
    int lmin;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        bits[n] = i;
        n++;
      end
    end
    lmax = 0;
    lmin = 1000;
    for (int d = 0; d < ND; d++) begin
      len[d] = n * (settle_of(d) + 1) + 1;
      if (len[d] > lmax) lmax = len[d];
      if (len[d] < lmin) lmin = len[d];
    end
    @(negedge clk);
    mux_in  = ins;
    ch_mask = mask;
    start   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= lmax + 1; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        int s;
        int k;
        logic [7:0] er;
        logic [2:0] es;
        s = settle_of(d);
        k = (c - 1) / (s + 1);
        if (k > n) k = n;
        er = 8'h00;
        for (int j = 0; j < k; j++) er[bits[j]] = ins[bits[j]];
        if (n == 0)         es = prev_sel[d];
        else if (c < len[d]) es = 3'(bits[(c - 1) / (s + 1)]);
        else                es = 3'(bits[n - 1]);
        chk("sel",  d, 32'(sel_v[d]),  32'(es));
        chk("busy", d, 32'(busy_v[d]), 32'(c <= len[d]));
        chk("done", d, 32'(done_v[d]), 32'(c == len[d]));
        chk("res",  d, 32'(res_v[d]),  32'(er));
        chk("rv",   d, 32'(rv_v[d]),   32'(c > len[d]));
      end
      start = disturb && (c <= lmin);
      if (disturb) ch_mask = ~mask;
    end
    start = 1'b0;
    if (n > 0) begin
      for (int d = 0; d < ND; d++) prev_sel[d] = 3'(bits[n - 1]);
    end
  endtask

  task automatic reset_mid_scan();
    @(negedge clk);
    mux_in  = 8'($urandom);
    ch_mask = 8'hFF;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    // Cycle 7 after the accepting edge: SETTLE=1 instance is settling channel 3.
    chk("pre_rst_sel",  0, 32'(sel_v[0]),  32'd3);
    chk("pre_rst_busy", 0, 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_reset("mid_rst");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk("post_rst_done", d, 32'(done_v[d]), 32'd0);
        chk("post_rst_busy", d, 32'(busy_v[d]), 32'd0);
      end
    end
    for (int d = 0; d < ND; d++) prev_sel[d] = 3'd0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    ch_mask = 8'hFF;
    mux_in  = 8'h00;
    for (int d = 0; d < ND; d++) prev_sel[d] = 3'd0;
    repeat (3) @(negedge clk);
    chk_idle_reset("reset");
    start = 1'b0;
    rst   = 1'b0;

    run_scan(8'hFF, 8'hA5, 1'b0);
    run_scan(8'h81, 8'hFF, 1'b0);
    run_scan(8'h00, 8'h3C, 1'b0);
    run_scan(8'h3C, 8'h5A, 1'b1);
    reset_mid_scan();
    run_scan(8'h00, 8'hFF, 1'b1);
    for (int t = 0; t < 14; t++) begin
      run_scan(8'($urandom), 8'($urandom), 1'($urandom));
    end
    run_scan(8'h80, 8'h80, 1'b0);
    run_scan(8'h01, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: SETTLE, 1, number of settle cycles after each sel change before y_in is sampled (legal range 0..15).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a scan; sampled only in IDLE.
REQ-005 Port: ch_mask  input  8  channel enable mask; bit i enables mux input Ii; captured on accepted start.
REQ-006 Port: y_in  input  1  Y output of the downstream 8:1 mux.
REQ-007 Port: sel  output  3  select driven to the mux S input; registered.
REQ-008 Port: busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-009 Port: done  output  1  one-cycle pulse at scan completion.
REQ-010 Port: result  output  8  result[i] = sampled Y for enabled channel i, 0 for disabled channels.
REQ-011 Port: result_valid  output  1  result holds a completed scan; stays high until next accepted start or reset.

Function
REQ-012 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE, with a 4-bit settle counter and an 8-bit pending-channel register.
REQ-013 IDLE: start=1 and ch_mask!=0 -> load pending=ch_mask, sel=lowest set index, clear result, result_valid=0, go SETTLE (or SAMPLE if SETTLE=0).
REQ-014 IDLE: start=1 and ch_mask==0 -> result=0, result_valid=0, go DONE directly; no channel is sampled.
REQ-015 SETTLE: counter SHALL count SETTLE cycles, then go SAMPLE; sel SHALL be held stable throughout.
REQ-016 SAMPLE (exactly one cycle): result[sel] <= y_in; clear pending[sel]; if any pending bit remains, sel <= lowest remaining set index and go SETTLE (or SAMPLE if SETTLE=0); else go DONE.
REQ-017 Channels SHALL be visited in strictly ascending index order; disabled channels SHALL never be driven on sel and never sampled.
REQ-018 DONE (exactly one cycle): done=1, result_valid <= 1, go IDLE; sel SHALL hold its last value.
REQ-019 Per enabled channel the scan SHALL take SETTLE+1 cycles; total from accepted start to done high = N*(SETTLE+1)+1 cycles, where N = popcount(ch_mask).
REQ-020 start SHALL be ignored in SETTLE, SAMPLE and DONE; ch_mask changes after acceptance SHALL have no effect on the running scan.
REQ-021 busy SHALL be 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-022 result SHALL only change in SAMPLE, on accepted start (cleared), and on reset.

Reset
REQ-023 With rst=1 at a clock edge: state=IDLE, sel=3'b000, busy=0, done=0, result=8'h00, result_valid=0, counter=0, pending=0.
REQ-024 Reset mid-scan SHALL abort the scan with no done pulse; partial results SHALL be discarded.
REQ-025 rst SHALL take priority over start in the same cycle.

Verification
REQ-026 SETTLE=1, mux inputs I7..I0=8'hA5, ch_mask=8'hFF, start pulse -> sel steps 0..7, done high 17 cycles after start, result=8'hA5, result_valid=1.
REQ-027 ch_mask=8'h81, I7..I0=8'hFF -> sel visits only 0 and 7, result=8'h81, done 5 cycles after start.
REQ-028 ch_mask=8'h00, start -> done pulse on the next cycle, result=8'h00, sel stays at its prior value.
REQ-029 start re-asserted with a different ch_mask while busy -> ignored; the original scan result is produced unchanged.
REQ-030 rst=1 during SETTLE of channel 3 -> next cycle sel=0, busy=0, result=8'h00, result_valid=0, and no done pulse.
REQ-031 SETTLE=0, ch_mask=8'hFF -> one channel per cycle, done 9 cycles after start, result matches mux inputs.
